// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : LEGv8 fetch front end with sequential PC generation, credit-
//               limited imem requests and an in-order PC-tagged word queue.
//               Define FETCHQ_BYPASS_EN to forward a response straight to the
//               consumer when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [63:0]              StartPC,
  output logic                     IMemReq,
  output logic [63:0]              IMemAddr,
  input  logic                     IMemGnt,
  input  logic                     IMemValid,
  input  logic [31:0]              IMemData,
  input  logic                     Redirect,
  input  logic [63:0]              RedirectPC,
  output logic                     InstrValid,
  output logic [31:0]              Instr,
  output logic [63:0]              InstrPC,
  input  logic                     InstrReady,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   data_q [DEPTH];
  logic [63:0]   pc_q   [DEPTH];

  logic [CW:0]   credit_w;
  logic          accept_w, resp_w, head_valid_w, bypass_w, push_w, pop_w;

  // Every outstanding request owns a queue slot, so the queue can never overflow.
  assign credit_w     = {1'b0, inflight_q} + {1'b0, count_q};
  assign IMemReq      = ~Reset & ~Redirect & (credit_w < (CW+1)'(DEPTH));
  assign IMemAddr     = fetch_pc_q;
  assign accept_w     = IMemReq & IMemGnt;
  assign resp_w       = IMemValid & (inflight_q != '0);
  assign head_valid_w = (count_q != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass_w = ~head_valid_w & (drop_q == '0) & ~Redirect & resp_w;
`else
  assign bypass_w = 1'b0;
`endif

  assign pop_w  = head_valid_w & InstrReady & ~Redirect;
  assign push_w = resp_w & (drop_q == '0) & ~Redirect & ~(bypass_w & InstrReady);

  assign InstrValid = head_valid_w | bypass_w;
  assign Instr      = bypass_w ? IMemData  : data_q[rd_q];
  assign InstrPC    = bypass_w ? resp_pc_q : pc_q[rd_q];
  assign Count      = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(accept_w) - CW'(resp_w);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push_w) - CW'(pop_w);
    rd_d       = pop_w  ? rd_q + PW'(1) : rd_q;
    wr_d       = push_w ? wr_q + PW'(1) : wr_q;
    if (accept_w)
      fetch_pc_d = fetch_pc_q + 64'd4;
    if (resp_w && (drop_q != '0))
      drop_d = drop_q - CW'(1);
    if (resp_w && (drop_q == '0))
      resp_pc_d = resp_pc_q + 64'd4;
    // Words still in flight after this cycle belong to the old path.
    if (Redirect) begin
      fetch_pc_d = RedirectPC;
      resp_pc_d  = RedirectPC;
      inflight_d = inflight_q - CW'(resp_w);
      drop_d     = inflight_q - CW'(resp_w);
      count_d    = '0;
      rd_d       = wr_q;
      wr_d       = wr_q;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_pc_q <= StartPC;
      resp_pc_q  <= StartPC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push_w) begin
      data_q[wr_q] <= IMemData;
      pc_q[wr_q]   <= resp_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (Reset)
    !(push_w && (count_q == CW'(DEPTH))));

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed and random stimulus for fetch_queue against a
//               queue-based reference model and an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] StartPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady;
  logic [2:0]  Count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .StartPC(StartPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
    .InstrReady(InstrReady), .Count(Count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] d; logic [63:0] pc; } ent_t;
  typedef struct { int rc; logic [31:0] d; } pend_t;

  ent_t        m_q[$];
  pend_t       pend[$];
  logic [63:0] m_fetch, m_resp;
  int          m_inflight, m_drop;
  int          cyc, last_rc;
  int          errors, checks, dut_grants;
  bit          stale;

  function automatic logic [31:0] memword(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_init(input logic [63:0] spc);
    m_fetch = spc; m_resp = spc; m_inflight = 0; m_drop = 0;
    m_q.delete(); pend.delete(); last_rc = -1;
  endtask

  // One clock: drive at negedge, check at negedge+1, then advance the model.
  task automatic cycle(input bit gnt, input bit rdy, input bit redir,
                       input logic [63:0] rpc, input int lat);
    logic        mv;
    logic [31:0] md;
    bit          byp, resp, exp_req, exp_valid;
    int          r;
    @(negedge CLK);
    mv = 1'b0; md = '0;
    if (stale) begin
      mv = 1'b1; md = 32'hBAD0_BAD0;
    end else if (pend.size() != 0 && pend[0].rc <= cyc) begin
      mv = 1'b1; md = pend[0].d;
    end
    IMemGnt = gnt; IMemValid = mv; IMemData = md;
    Redirect = redir; RedirectPC = rpc; InstrReady = rdy;
    #1;
    exp_req = !redir && (m_inflight + m_q.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (m_q.size() == 0) && (m_drop == 0) && !redir && mv && (m_inflight > 0);
`endif
    exp_valid = (m_q.size() != 0) || byp;
    chk("IMemReq",    64'(IMemReq),    64'(exp_req));
    chk("IMemAddr",   IMemAddr,        m_fetch);
    chk("InstrValid", 64'(InstrValid), 64'(exp_valid));
    chk("Count",      64'(Count),      64'(m_q.size()));
    if (m_q.size() != 0) begin
      chk("Instr",   64'(Instr), 64'(m_q[0].d));
      chk("InstrPC", InstrPC,    m_q[0].pc);
    end else if (byp) begin
      chk("BypInstr",   64'(Instr), 64'(md));
      chk("BypInstrPC", InstrPC,    m_resp);
    end
    if (IMemReq && gnt) dut_grants++;

    resp = mv && (m_inflight > 0);
    if (redir) begin
      if (resp) m_inflight--;
      m_drop = m_inflight;
      m_q.delete();
      m_fetch = rpc; m_resp = rpc;
    end else begin
      if (exp_valid && rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (resp) begin
        m_inflight--;
        if (m_drop > 0) m_drop--;
        else begin
          if (!(byp && rdy)) m_q.push_back({md, m_resp});
          m_resp = m_resp + 64'd4;
        end
      end
      if (exp_req && gnt) begin
        r = cyc + lat;
        if (r <= last_rc) r = last_rc + 1;
        last_rc = r;
        pend.push_back('{rc: r, d: memword(m_fetch)});
        m_fetch = m_fetch + 64'd4;
        m_inflight++;
      end
    end
    if (mv && !stale) void'(pend.pop_front());
    cyc++;
  endtask

  task automatic do_reset(input logic [63:0] spc);
    @(negedge CLK);
    Reset = 1'b1; StartPC = spc; IMemGnt = 1'b0; IMemValid = 1'b0;
    Redirect = 1'b0; InstrReady = 1'b0;
    @(posedge CLK); #1;
    chk("rst_IMemReq",    64'(IMemReq),    64'd0);
    chk("rst_IMemAddr",   IMemAddr,        spc);
    chk("rst_InstrValid", 64'(InstrValid), 64'd0);
    chk("rst_Instr",      64'(Instr),      64'd0);
    chk("rst_InstrPC",    InstrPC,         64'd0);
    chk("rst_Count",      64'(Count),      64'd0);
    @(negedge CLK);
    Reset = 1'b0;
    model_init(spc);
    #1 chk("req_after_reset", 64'(IMemReq), 64'd1);
  endtask

  task automatic async_reset(input logic [63:0] spc);
    @(negedge CLK);
    #1 chk("pre_rst_count", 64'(Count), 64'd2);
    #1;
    StartPC = spc; Reset = 1'b1;
    IMemGnt = 1'b0; IMemValid = 1'b0; Redirect = 1'b0;
    #1;
    chk("arst_IMemReq",    64'(IMemReq),    64'd0);
    chk("arst_IMemAddr",   IMemAddr,        spc);
    chk("arst_InstrValid", 64'(InstrValid), 64'd0);
    chk("arst_Instr",      64'(Instr),      64'd0);
    chk("arst_InstrPC",    InstrPC,         64'd0);
    chk("arst_Count",      64'(Count),      64'd0);
    @(negedge CLK);
    Reset = 1'b0;
    model_init(spc);
    #1 chk("req_after_arst", 64'(IMemReq), 64'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pend.size() == 0 && m_q.size() == 0 && m_inflight == 0) begin
        done = 1'b1;
        break;
      end
      cycle(1'b0, 1'b1, 1'b0, 64'd0, 1);
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rp;
    errors = 0; checks = 0; cyc = 0; stale = 1'b0; dut_grants = 0;
    Reset = 1'b1; StartPC = 64'h100; IMemGnt = 1'b0; IMemValid = 1'b0;
    IMemData = '0; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
    model_init(64'h100);

    // Streaming with a 1-cycle memory.
    do_reset(64'h100);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 64'd0, 1);

    // Consumer stalled: credits run out after DEPTH grants.
    drain();
    dut_grants = 0;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
    @(posedge CLK); #1;
    chk("stall_grants", 64'(dut_grants), 64'd4);
    chk("stall_count",  64'(Count),      64'd4);
    chk("stall_req",    64'(IMemReq),    64'd0);
    cycle(1'b1, 1'b1, 1'b0, 64'd0, 1);
    @(posedge CLK); #1;
    chk("req_after_pop", 64'(IMemReq), 64'd1);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 64'd0, 1);

    // Two slow words in flight, then a redirect drops both.
    drain();
    cycle(1'b1, 1'b1, 1'b0, 64'd0, 3);
    cycle(1'b1, 1'b1, 1'b0, 64'd0, 3);
    cycle(1'b0, 1'b1, 1'b1, 64'h400, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
      if (m_q.size() != 0) break;
    end
    @(posedge CLK); #1;
    chk("redir_valid",   64'(InstrValid), 64'd1);
    chk("redir_head_pc", InstrPC,         64'h400);

    // Redirect coinciding with a response and a pop.
    drain();
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
    cycle(1'b0, 1'b1, 1'b1, 64'h800, 1);
    @(posedge CLK); #1;
    chk("redir_resp_count", 64'(Count), 64'd0);
    chk("redir_resp_addr",  IMemAddr,   64'h800);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 64'd0, 1);

    // Asynchronous reset with two words queued, then a stale response.
    drain();
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 1);
    async_reset(64'h2000);
    stale = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 64'd0, 1);
    stale = 1'b0;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 64'd0, 1);

    // Random grants, stalls, latencies and redirects (including PC wrap).
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
      else begin
        rp = {$urandom, $urandom};
        rp[1:0] = 2'b00;
      end
      cycle($urandom_range(3) != 0, $urandom_range(2) != 0,
            $urandom_range(24) == 0, rp, 1 + $urandom_range(3));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
